// File: rtl/nap_pkt_pkg.sv
// Shared NAP packet definitions: beat field layout and sender FSM states.
// The receiver decodes beats using the same field constants.
package nap_pkt_pkg;

  localparam int SEQ_LSB  = 24;
  localparam int BEAT_LSB = 16;
  localparam int LEN_LSB  = 0;
  localparam int FIELD_W  = 8;
  localparam int LEN_W    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/t_data_stream.sv
// NAP data-stream bundle: valid/ready handshake carrying data, destination
// address and start/end-of-packet markers.
interface t_DATA_STREAM #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              sop;
  logic              eop;

  modport tx (output valid, data, addr, sop, eop, input ready);
  modport rx (input valid, data, addr, sop, eop, output ready);

endinterface

// File: rtl/pkt_sender_trigger_timer.sv
// Periodic trigger source: a down-counter that pulses timer_tick for one
// cycle every AUTO_PERIOD cycles. AUTO_PERIOD = 0 disables it entirely.
module trigger_timer #(
  parameter int AUTO_PERIOD = 0
) (
  input  logic clk,
  input  logic resetn,
  output logic timer_tick
);

  generate
    if (AUTO_PERIOD == 0) begin : g_off
      // Clock and reset are not needed when the timer is disabled.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, resetn};
      assign timer_tick    = 1'b0;
    end else begin : g_on
      localparam int CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [CNT_W-1:0] RELOAD = CNT_W'(AUTO_PERIOD - 1);

      logic [CNT_W-1:0] cnt_q;

      // Count down to zero, then reload on the same cycle the tick fires.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt_q <= '0;
        end else if (cnt_q == '0) begin
          cnt_q <= RELOAD;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end

      assign timer_tick = (cnt_q == '0);
    end
  endgenerate

endmodule

// File: rtl/pkt_sender.sv
// NAP packet sender: on a trigger (send pulse or periodic timer) emits one
// PKT_BEATS-long packet to DEST_ADDR. Every beat carries the packet sequence
// number, its beat index and the packet length so the far end can count.
module pkt_sender
  import nap_pkt_pkg::*;
#(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 4,
  parameter int DEST_ADDR   = 0,
  parameter int PKT_BEATS   = 4,
  parameter int AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        send,
  output logic        busy,
  output logic [31:0] pkt_count,
  t_DATA_STREAM.tx    tx
);

  localparam logic [FIELD_W-1:0] LAST_IDX = FIELD_W'(PKT_BEATS - 1);
  localparam logic [ADDR_W-1:0]  DEST     = ADDR_W'(DEST_ADDR);

  // Assemble one beat: sequence, beat index and length; all other bits zero.
  function automatic logic [DATA_W-1:0] beat_data(input logic [FIELD_W-1:0] seq,
                                                  input logic [FIELD_W-1:0] idx);
    logic [DATA_W-1:0] d;
    d                       = '0;
    d[SEQ_LSB  +: FIELD_W]  = seq;
    d[BEAT_LSB +: FIELD_W]  = idx;
    d[LEN_LSB  +: LEN_W]    = LEN_W'(PKT_BEATS);
    return d;
  endfunction

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [FIELD_W-1:0] idx_q, idx_d;
  logic [FIELD_W-1:0] seq_q, seq_d;
  logic               pending_q, pending_d;
  logic [31:0]        count_q, count_d;
  logic               timer_tick;
  logic               trig;
  logic               xfer;

  trigger_timer #(
    .AUTO_PERIOD (AUTO_PERIOD)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .timer_tick (timer_tick)
  );

  assign trig = send | timer_tick;
  assign xfer = valid_q & tx.ready;

  // Register all FSM state and the registered tx outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic: launch a packet from IDLE, advance beats in SEND and
  // remember a single trigger that arrives while a packet is in flight.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    data_d    = data_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (trig || pending_q) begin
          state_d   = SEND;
          valid_d   = 1'b1;
          sop_d     = 1'b1;
          eop_d     = (LAST_IDX == '0);
          idx_d     = '0;
          data_d    = beat_data(seq_q, '0);
          addr_d    = DEST;
          pending_d = 1'b0;
        end
      end
      SEND: begin
        if (trig) begin
          pending_d = 1'b1;
        end
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            seq_d   = seq_q + 8'd1;
            count_d = count_q + 32'd1;
          end else begin
            idx_d  = idx_q + 8'd1;
            sop_d  = 1'b0;
            eop_d  = ((idx_q + 8'd1) == LAST_IDX);
            data_d = beat_data(seq_q, idx_q + 8'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx.valid  = valid_q;
  assign tx.sop    = sop_q;
  assign tx.eop    = eop_q;
  assign tx.data   = data_q;
  assign tx.addr   = addr_q;
  assign busy      = (state_q == SEND);
  assign pkt_count = count_q;

endmodule

// File: doc/pkt_sender.md
Name: pkt_sender

Overview:
- Transmit-side counterpart of the NoC LED receiver.
- On a trigger (external pulse or internal periodic timer), emits one multi-beat packet over the NAP data-stream tx interface to a fixed destination NAP.
- Byte [31:24] of every beat carries an 8-bit packet sequence number, so the far-end receiver's LEDs count packets.
- Sits between board-level controls (button/timer) and the NAP tx modport.

Parameters:
- DATA_W, 256, width of tx.data
- ADDR_W, 4, width of tx.addr (destination NAP id)
- DEST_ADDR, 0, value driven on tx.addr for every beat
- PKT_BEATS, 4, beats per packet; legal range 1..255
- AUTO_PERIOD, 0, clk cycles between automatic triggers; 0 disables the timer

Ports:
- clk  input  1  sole clock
- resetn  input  1  reset, asynchronous assert, active-low
- send  input  1  single-cycle trigger request, synchronous to clk
- busy  output  1  high while a packet is in flight (SEND state)
- pkt_count  output  32  packets fully transferred since reset
- tx  t_DATA_STREAM.tx  -  drives valid, data[DATA_W], addr[ADDR_W], sop, eop; samples ready

Behaviour:
- Reset (resetn low, asynchronous):
  - tx.valid, tx.sop, tx.eop, tx.data, tx.addr, busy, pkt_count, sequence number, beat index, pending flag, timer all 0.
- Transfer rule:
  - A beat transfers on any clk edge where tx.valid & tx.ready.
  - Once valid is asserted, valid, data, addr, sop and eop hold stable until that beat transfers.
- Trigger: trig = send | timer_tick.
- Timer:
  - When AUTO_PERIOD > 0, a down-counter loads AUTO_PERIOD-1 and decrements each cycle.
  - timer_tick is high for one cycle at 0, and the counter reloads on the same cycle.
- State IDLE:
  - If trig or pending: next cycle is SEND, tx.valid=1, sop=1, beat index=0, and pending clears.
  - Latency: trigger sampled at edge N gives valid+sop visible after edge N (one cycle).
- State SEND, beat format:
  - data[31:24] = seq
  - data[23:16] = beat index
  - data[15:0] = PKT_BEATS
  - all other data bits 0
  - addr = DEST_ADDR
  - sop = (index==0); eop = (index==PKT_BEATS-1)
- State SEND, on transfer of a non-last beat:
  - Index increments, sop drops, and the next beat is presented on the following cycle with valid held high (no bubble).
- State SEND, on transfer of the eop beat:
  - valid, sop and eop go 0; state returns to IDLE.
  - seq increments and wraps 255 to 0; pkt_count increments and wraps at 2^32.
  - There is a minimum one-cycle gap (valid low) between packets.
- Trigger while in SEND, or during the eop-transfer cycle:
  - Sets pending. Only one pending trigger is held; further triggers while pending are dropped.
- PKT_BEATS=1: the single beat has sop=1 and eop=1.
- busy = (state==SEND).
- Reset mid-packet: valid drops immediately with no eop and the packet is truncated. After reset, seq restarts at 0. The far end tolerates the truncated packet.
- ready is ignored while valid is low; valid never depends combinationally on ready.

Decomposition:
- Shared package nap_pkt_pkg:
  - Field offset constants SEQ_LSB=24, BEAT_LSB=16, LEN_LSB=0.
  - Field width constant 8.
  - State enum typedef {IDLE, SEND}.
- The receiver decodes the same fields from this package.
- One natural sub-module: trigger_timer (AUTO_PERIOD down-counter producing timer_tick; tied off when AUTO_PERIOD=0).

Test Plan:
- PKT_BEATS=4, ready always 1, send pulse at cycle 10 -> valid high for cycles 11-14; beat indices 0..3; sop only on the first beat, eop only on the last; data[31:24]=0x00, data[15:0]=0x0004; pkt_count=1 after; busy low again at cycle 15.
- Ready toggled 1,0,0,1,... during packet -> each beat held unchanged while ready=0; exactly 4 transfers; no duplicated or skipped index.
- send pulses at cycle 10, 12 and 13 -> exactly two packets; the second sop appears after a single idle cycle following the first eop; seq values 0x00 then 0x01.
- 257 send pulses, one per packet completion -> data[31:24] of packet 257 = 0x00 (wrapped); pkt_count=257.
- resetn low during the beat with index 2 -> valid=0 asynchronously, before the next edge; after release, the next send yields sop with seq=0 and pkt_count=0 before completion.
- PKT_BEATS=1, AUTO_PERIOD=20, send tied 0 -> one-beat packets with sop=eop=1, starting every 20 cycles; seq increments each packet.
